// File: rtl/result_packer.sv
// result_packer: samples a held upstream result once every 4 cycles after a
// start strobe and queues it in a small FIFO that drains as an AXI-Stream
// master. Bursts are delimited by tlast every BURST_LEN beats. A sample that
// finds the FIFO full and not draining is dropped and flagged in the sticky
// overflow output.
//
// Optional feature: define RESULT_PACKER_DROP_CNT_EN to add a 16-bit
// saturating drop_cnt output that counts dropped samples.
module result_packer #(
    parameter int DEPTH     = 4,
    parameter int BURST_LEN = 8
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        ld,
    input  logic        stop,
    input  logic [31:0] din,
    input  logic        m_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        overflow
`ifdef RESULT_PACKER_DROP_CNT_EN
    ,
    output logic [15:0] drop_cnt
`endif
);

    // Pointer width indexes DEPTH entries; count width must also hold DEPTH.
    localparam int              PW           = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW           = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   LP_DEPTH     = CW'(DEPTH);
    localparam logic [7:0]      LP_LAST_BEAT = 8'(BURST_LEN - 1);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t          r_state;
    logic [1:0]      r_phase;
    logic [31:0]     r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [7:0]      r_beat;
    logic            r_overflow;

    logic            w_valid;
    logic            w_pop;
    logic            w_capture;
    logic            w_accept;
    logic            w_drop;

    // Handshake and capture decisions, all derived from registered state.
    assign w_valid   = (r_count != '0);
    assign w_pop     = w_valid && m_axis_tready;
    assign w_capture = (r_state == ST_RUN) && (r_phase == 2'd0);
    // A full FIFO can still take the sample when the head leaves on the same edge.
    assign w_accept  = w_capture && ((r_count < LP_DEPTH) || w_pop);
    assign w_drop    = w_capture && !w_accept;

    // Control FSM: IDLE waits for ld, RUN steps the 4-cycle sampling phase.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order statements are evaluated.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= ST_IDLE;
            r_phase <= 2'd0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (ld) begin
                        r_state <= ST_RUN;
                        r_phase <= 2'd0;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_phase <= 2'd0;
                    end else begin
                        r_phase <= r_phase + 2'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_phase <= 2'd0;
                end
            endcase
        end
    end

    // FIFO storage write port.
    // NOTE: the storage array has no reset; entries are only observable once
    // the count says they were written, and the output mux below forces zero
    // while the FIFO is empty.
    always_ff @(posedge aclk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            unique case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Beat counter: counts accepted beats modulo BURST_LEN to place tlast.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_beat <= 8'd0;
        end else if (w_pop) begin
            if (r_beat == LP_LAST_BEAT) begin
                r_beat <= 8'd0;
            end else begin
                r_beat <= r_beat + 8'd1;
            end
        end
    end

    // Sticky overflow: set on any dropped sample, cleared only by reset.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef RESULT_PACKER_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    // Saturating count of dropped samples.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_drop_cnt <= 16'd0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign m_axis_tvalid = w_valid;
    assign m_axis_tdata  = w_valid ? r_mem[r_rd_ptr] : 32'h0;
    assign m_axis_tlast  = w_valid && (r_beat == LP_LAST_BEAT);
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_result_packer.sv
// Self-checking bench for result_packer. A transaction-level model (a queue
// of words, a running flag with an age counter, a pop tally) predicts the
// stream outputs after every clock edge. Works with or without
// RESULT_PACKER_DROP_CNT_EN.
module tb_result_packer;

    localparam int DEPTH     = 4;
    localparam int BURST_LEN = 8;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        ld = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] din = 32'h0;
    logic        m_axis_tready = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        overflow;
`ifdef RESULT_PACKER_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    result_packer #(
        .DEPTH    (DEPTH),
        .BURST_LEN(BURST_LEN)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .ld           (ld),
        .stop         (stop),
        .din          (din),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .overflow     (overflow)
`ifdef RESULT_PACKER_DROP_CNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [31:0] m_q[$];
    bit          m_run;
    int          m_age;     // edges elapsed since entering run
    int          m_beats;   // total words handed downstream
    bit          m_ovf;
    int          m_drops;

    task automatic model_reset();
        m_q.delete();
        m_run   = 1'b0;
        m_age   = 0;
        m_beats = 0;
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    // One clock edge of the model, using the inputs presented before the edge.
    task automatic model_edge(input logic s_ld, input logic s_stop,
                              input logic s_rdy, input logic [31:0] s_din);
        logic [31:0] dummy;
        bit          pop;
        bit          cap;
        pop = (m_q.size() != 0) && s_rdy;
        // Samples are taken one edge after start, then every fourth edge.
        cap = m_run && ((m_age % 4) == 0);
        if (pop) begin
            dummy = m_q.pop_front();
            m_beats++;
        end
        if (cap) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(s_din);
            end else begin
                m_ovf = 1'b1;
                m_drops++;
            end
        end
        if (m_run) begin
            if (s_stop) m_run = 1'b0;
            m_age++;
        end else if (s_ld) begin
            m_run = 1'b1;
            m_age = 0;
        end
    endtask

    function automatic logic [50:0] exp_vec();
        logic        has;
        logic [15:0] d;
        has = (m_q.size() != 0);
        d   = (m_drops > 65535) ? 16'hFFFF : 16'(m_drops);
`ifndef RESULT_PACKER_DROP_CNT_EN
        d   = 16'h0;
`endif
        return {has, has && ((m_beats % BURST_LEN) == BURST_LEN - 1), m_ovf,
                has ? m_q[0] : 32'h0, d};
    endfunction

    function automatic logic [50:0] obs_vec();
        logic [15:0] d;
        d = 16'h0;
`ifdef RESULT_PACKER_DROP_CNT_EN
        d = drop_cnt;
`endif
        return {m_axis_tvalid, m_axis_tlast, overflow,
                m_axis_tvalid ? m_axis_tdata : 32'h0, d};
    endfunction

    // Present inputs at the falling edge, advance the model at the rising
    // edge, return at the next falling edge.
    task automatic step(input logic s_ld, input logic s_stop,
                        input logic s_rdy, input logic [31:0] s_din);
        ld            = s_ld;
        stop          = s_stop;
        m_axis_tready = s_rdy;
        din           = s_din;
        @(posedge aclk);
        model_edge(s_ld, s_stop, s_rdy, s_din);
        @(negedge aclk);
    endtask

    task automatic do_reset();
        areset        = 1'b1;
        ld            = 1'b0;
        stop          = 1'b0;
        m_axis_tready = 1'b0;
        model_reset();
        @(negedge aclk);
        areset = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({m_axis_tvalid, m_axis_tlast, overflow} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000", {m_axis_tvalid, m_axis_tlast, overflow});
        end
        n_checks++;
        if (m_axis_tdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_tdata: got %h expected 00000000", m_axis_tdata);
        end
`ifdef RESULT_PACKER_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_drop_cnt: got %h expected 0000", drop_cnt);
        end
`endif
        areset = 1'b0;
        model_reset();
        // ld is absent, so nothing may appear.
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b1, 32'hDEAD0000 + 32'(k));
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_idle step %0d: got %h expected %h", k, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        do_reset();
        step(1'b1, 1'b0, 1'b1, 32'h11111111);
        for (int k = 1; k <= 14; k++) begin
            d = (k <= 4) ? 32'h11111111 : (k <= 8) ? 32'h22222222 : 32'h33333333;
            step(1'b0, (k == 14), 1'b1, d);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL basic step %0d: got %h expected %h", k, obs_vec(), exp_vec());
            end
            if (k == 1 || k == 5) begin
                n_checks++;
                if (!(m_axis_tvalid === 1'b1 && m_axis_tdata === ((k == 1) ? 32'h11111111 : 32'h22222222))) begin
                    n_fail++;
                    $display("FAIL basic_latency step %0d: got valid=%b data=%h", k, m_axis_tvalid, m_axis_tdata);
                end
            end
        end
    endtask

    task automatic test_burst();
        int pops;
        int lasts[$];
        do_reset();
        step(1'b1, 1'b0, 1'b1, 32'h0);
        pops = 0;
        for (int k = 1; k <= 64; k++) begin
            if (m_axis_tvalid === 1'b1) begin
                pops++;
                if (m_axis_tlast === 1'b1) lasts.push_back(pops);
            end
            step(1'b0, (k == 64), 1'b1, $urandom);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL burst step %0d: got %h expected %h", k, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (pops != 16 || lasts.size() != 2) begin
            n_fail++;
            $display("FAIL burst_count: got pops=%0d lasts=%0d expected 16 and 2", pops, lasts.size());
        end else begin
            n_checks++;
            if (lasts[0] != 8 || lasts[1] != 16) begin
                n_fail++;
                $display("FAIL burst_tlast_pos: got %0d,%0d expected 8,16", lasts[0], lasts[1]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] vals[6];
        logic [31:0] got[$];
        for (int i = 0; i < 6; i++) vals[i] = $urandom;
        do_reset();
        step(1'b1, 1'b0, 1'b0, vals[0]);
        for (int k = 1; k <= 22; k++) begin
            step(1'b0, (k == 22), 1'b0, vals[(k - 1) / 4]);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL overflow step %0d: got %h expected %h", k, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (overflow !== 1'b1 || m_axis_tdata !== vals[0]) begin
            n_fail++;
            $display("FAIL overflow_flag: got ovf=%b head=%h expected 1 %h", overflow, m_axis_tdata, vals[0]);
        end
`ifdef RESULT_PACKER_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL overflow_drop_cnt: got %0d expected 2", drop_cnt);
        end
`endif
        for (int k = 0; k < 8; k++) begin
            if (m_axis_tvalid === 1'b1) got.push_back(m_axis_tdata);
            step(1'b0, 1'b0, 1'b1, 32'h0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL overflow_drain step %0d: got %h expected %h", k, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (got.size() != 4) begin
            n_fail++;
            $display("FAIL overflow_drain_count: got %0d expected 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (got[i] !== vals[i]) begin
                    n_fail++;
                    $display("FAIL overflow_order %0d: got %h expected %h", i, got[i], vals[i]);
                end
            end
        end
    endtask

    // Runs straight after test_overflow: overflow and beat count carry over.
    task automatic test_reset_mid();
        int seen;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b0, 1'b0, $urandom);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_mid_fill step %0d: got %h expected %h", k, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (overflow !== 1'b1 || m_q.size() != 3) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got ovf=%b model words=%0d expected 1 and 3", overflow, m_q.size());
        end
        areset = 1'b1;
        #1;
        n_checks++;
        if ({m_axis_tvalid, m_axis_tlast, overflow, m_axis_tdata} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got valid=%b last=%b ovf=%b data=%h expected all 0",
                     m_axis_tvalid, m_axis_tlast, overflow, m_axis_tdata);
        end
        model_reset();
        @(negedge aclk);
        areset = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b0, 1'b1, $urandom);
            if (m_axis_tvalid !== 1'b0) seen++;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_mid_after step %0d: got %h expected %h", k, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_mid_beats: got %0d valid cycles expected 0", seen);
        end
    endtask

    task automatic test_full_pop();
        logic [31:0] vals[5];
        logic [31:0] got[$];
        for (int i = 0; i < 5; i++) vals[i] = $urandom;
        do_reset();
        step(1'b1, 1'b0, 1'b0, vals[0]);
        for (int k = 1; k <= 18; k++) begin
            step(1'b0, (k == 18), (k == 17), vals[(k - 1) / 4]);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL full_pop step %0d: got %h expected %h", k, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (overflow !== 1'b0 || m_axis_tdata !== vals[1]) begin
            n_fail++;
            $display("FAIL full_pop_flag: got ovf=%b head=%h expected 0 %h", overflow, m_axis_tdata, vals[1]);
        end
        for (int k = 0; k < 8; k++) begin
            if (m_axis_tvalid === 1'b1) got.push_back(m_axis_tdata);
            step(1'b0, 1'b0, 1'b1, 32'h0);
        end
        n_checks++;
        if (got.size() != 4) begin
            n_fail++;
            $display("FAIL full_pop_count: got %0d expected 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (got[i] !== vals[i + 1]) begin
                    n_fail++;
                    $display("FAIL full_pop_order %0d: got %h expected %h", i, got[i], vals[i + 1]);
                end
            end
        end
    endtask

    task automatic test_stop();
        int pops;
        do_reset();
        step(1'b1, 1'b0, 1'b1, 32'h0);
        pops = 0;
        for (int k = 1; k <= 15; k++) begin
            if (m_axis_tvalid === 1'b1) pops++;
            step(1'b0, (k == 5), 1'b1, 32'hA0000000 + 32'(k));
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL stop step %0d: got %h expected %h", k, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (pops != 2) begin
            n_fail++;
            $display("FAIL stop_words: got %0d expected 2", pops);
        end
        step(1'b1, 1'b0, 1'b1, 32'h0);
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_early: got valid=%b expected 0", m_axis_tvalid);
        end
        step(1'b0, 1'b0, 1'b1, 32'hCAFEF00D);
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL restart_first: got valid=%b data=%h expected 1 cafef00d", m_axis_tvalid, m_axis_tdata);
        end
        step(1'b0, 1'b1, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 2) != 0), $urandom);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random step %0d: got %h expected %h", k, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        @(negedge aclk);
        test_reset();
        test_basic();
        test_burst();
        test_overflow();
        test_reset_mid();
        test_full_pop();
        test_stop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
